// File: rtl/clk_gen_mc_pkg.sv
// Shared register offsets, read-back record and helpers for the multi-channel clock generator.
package clk_gen_mc_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DIV_LO = 4'h1;
    localparam logic [3:0] REG_DIV_HI = 4'h2;
    localparam logic [3:0] REG_BURST  = 4'h3;
    localparam logic [3:0] REG_SYNC   = 4'h5;

    localparam int SYNC_W = 8;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] div_lo;
        logic [7:0] div_hi;
        logic [7:0] burst;
    } ch_rd_t;

    function automatic logic [7:0] ctrl_byte(input logic en, input logic pol, input logic busy);
        return {busy, 5'b00000, pol, en};
    endfunction

endpackage

// File: rtl/clk_gen_mc_ch.sv
// One clock channel: control registers, phase counter, burst auto-stop and edge strobes.
module clk_gen_mc_ch
    import clk_gen_mc_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_wr_ctrl,
    input  logic               i_en_val,
    input  logic               i_pol_val,
    input  logic               i_wr_div,
    input  logic [DIV_W-1:0]   i_div_val,
    input  logic               i_wr_burst,
    input  logic [BURST_W-1:0] i_burst_val,
    input  logic               i_sync,
    output ch_rd_t             o_rd,
    output logic               o_clk,
    output logic               o_pos,
    output logic               o_neg
);

    logic               r_en, r_pol, r_phase, r_clk, r_pos, r_neg;
    logic [DIV_W-1:0]   r_div, r_cnt;
    logic [BURST_W-1:0] r_burst, r_pcnt;

    logic               w_en_n, w_pol_n, w_phase_n, w_clk_n, w_restart, w_wr_any;
    logic [DIV_W-1:0]   w_div_n, w_cnt_n;
    logic [BURST_W-1:0] w_burst_n, w_pcnt_n;
    logic [15:0]        w_div16;

    assign w_wr_any = i_wr_ctrl | i_wr_div | i_wr_burst | i_sync;
    assign w_div16  = 16'(r_div);

    assign o_rd.ctrl   = ctrl_byte(r_en, r_pol, r_en);
    assign o_rd.div_lo = w_div16[7:0];
    assign o_rd.div_hi = w_div16[15:8];
    assign o_rd.burst  = 8'(r_burst);
    assign o_clk       = r_clk;
    assign o_pos       = r_pos;
    assign o_neg       = r_neg;

    // Next-state: bus writes first, then the counter; a write suppresses burst auto-stop.
    always_comb begin
        w_en_n    = r_en;
        w_pol_n   = r_pol;
        w_div_n   = r_div;
        w_burst_n = r_burst;
        w_restart = 1'b0;
        if (i_sync) begin
            w_en_n    = 1'b1;
            w_restart = 1'b1;
        end else if (i_wr_ctrl) begin
            w_en_n    = i_en_val;
            w_pol_n   = i_pol_val;
            w_restart = i_en_val & ~r_en;
        end else if (i_wr_div) begin
            w_div_n   = i_div_val;
            w_restart = 1'b1;
        end else if (i_wr_burst) begin
            w_burst_n = i_burst_val;
        end else begin
            w_restart = 1'b0;
        end

        w_cnt_n   = r_cnt;
        w_phase_n = r_phase;
        w_pcnt_n  = r_pcnt;
        if (!r_en || w_restart) begin
            w_cnt_n   = '0;
            w_phase_n = 1'b0;
            w_pcnt_n  = '0;
        end else if (r_cnt == r_div) begin
            w_cnt_n   = '0;
            w_phase_n = ~r_phase;
            if (r_phase && (r_burst != '0)) begin
                if (r_pcnt >= (r_burst - BURST_W'(1))) begin
                    w_pcnt_n = '0;
                    w_en_n   = w_wr_any ? w_en_n : 1'b0;
                end else begin
                    w_pcnt_n = r_pcnt + BURST_W'(1);
                end
            end else begin
                w_pcnt_n = r_pcnt;
            end
        end else begin
            w_cnt_n = r_cnt + DIV_W'(1);
        end

        w_clk_n = w_en_n ? (w_phase_n ^ w_pol_n) : w_pol_n;
    end

    // Channel state and registered clock/strobe outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en    <= 1'b0;
            r_pol   <= 1'b0;
            r_div   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_pcnt  <= '0;
            r_clk   <= 1'b0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_en    <= w_en_n;
            r_pol   <= w_pol_n;
            r_div   <= w_div_n;
            r_burst <= w_burst_n;
            r_cnt   <= w_cnt_n;
            r_phase <= w_phase_n;
            r_pcnt  <= w_pcnt_n;
            r_clk   <= w_clk_n;
            r_pos   <= w_clk_n & ~r_clk;
            r_neg   <= ~w_clk_n & r_clk;
        end
    end

endmodule

// File: rtl/clk_gen_mc.sv
// Bus front end: address decode, SYNC fan-out, DIV_LO shadows and the ack/read mux over CHANNELS channels.
module clk_gen_mc
    import clk_gen_mc_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16,
    parameter int BURST_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [7:0]          adr_i,
    input  logic [7:0]          dat_i,
    output logic [7:0]          dat_o,
    output logic                ack_o,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] clk_pos,
    output logic [CHANNELS-1:0] clk_neg
);

    logic [3:0] w_ch, w_reg;
    logic       w_ch_ok, w_wr, w_sync_wr;
    logic [7:0] w_rdata;
    logic [7:0] r_shadow [CHANNELS];
    ch_rd_t     w_rd [16];

    assign w_ch      = adr_i[7:4];
    assign w_reg     = adr_i[3:0];
    assign w_ch_ok   = ({1'b0, w_ch} < 5'(CHANNELS));
    assign w_wr      = stb_i & we_i & w_ch_ok;
    assign w_sync_wr = w_wr & (w_reg == REG_SYNC);

    // Unpopulated channel slots read back as zero, which covers out-of-range channel reads.
    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < CHANNELS) begin : g_on
            logic w_sel, w_sync;
            assign w_sel = w_wr & (w_ch == 4'(i));
            if (i < SYNC_W) begin : g_sync
                assign w_sync = w_sync_wr & dat_i[i];
            end else begin : g_nosync
                assign w_sync = 1'b0;
            end
            clk_gen_mc_ch #(
                .DIV_W  (DIV_W),
                .BURST_W(BURST_W)
            ) u_ch (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .i_wr_ctrl  (w_sel & (w_reg == REG_CTRL)),
                .i_en_val   (dat_i[0]),
                .i_pol_val  (dat_i[1]),
                .i_wr_div   (w_sel & (w_reg == REG_DIV_HI)),
                .i_div_val  (DIV_W'({dat_i, r_shadow[i]})),
                .i_wr_burst (w_sel & (w_reg == REG_BURST)),
                .i_burst_val(BURST_W'(dat_i)),
                .i_sync     (w_sync),
                .o_rd       (w_rd[i]),
                .o_clk      (clk_out[i]),
                .o_pos      (clk_pos[i]),
                .o_neg      (clk_neg[i])
            );
        end else begin : g_off
            assign w_rd[i] = '0;
        end
    end

    // Read mux.
    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            REG_CTRL:   w_rdata = w_rd[w_ch].ctrl;
            REG_DIV_LO: w_rdata = w_rd[w_ch].div_lo;
            REG_DIV_HI: w_rdata = w_rd[w_ch].div_hi;
            REG_BURST:  w_rdata = w_rd[w_ch].burst;
            default:    w_rdata = 8'h00;
        endcase
    end

    // DIV_LO shadow registers, committed to the channel by a DIV_HI write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shadow[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_wr && (w_reg == REG_DIV_LO) && (w_ch == 4'(k))) begin
                    r_shadow[k] <= dat_i;
                end else begin
                    r_shadow[k] <= r_shadow[k];
                end
            end
        end
    end

    // Bus acknowledge and read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            dat_o <= 8'h00;
        end else begin
            ack_o <= stb_i;
            dat_o <= (stb_i && !we_i) ? w_rdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_clk_gen_mc.sv
// Scoreboard bench: driver pushes model expectations per clock edge, monitor pops and compares.
module tb_clk_gen_mc;

    localparam int CH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, stb_i, we_i, ack_o;
    logic [7:0]    adr_i, dat_i, dat_o;
    logic [CH-1:0] clk_out, clk_pos, clk_neg;

    always #5 clk_i = ~clk_i;

    clk_gen_mc #(.CHANNELS(CH), .DIV_W(16), .BURST_W(8)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .clk_out(clk_out),
        .clk_pos(clk_pos),
        .clk_neg(clk_neg)
    );

    typedef struct { int n; logic [7:0] val; } bus_t;
    typedef struct { int n; logic [CH-1:0] o; logic [CH-1:0] p; logic [CH-1:0] g; } clk_t;

    int n_vec = 0;
    int n_err = 0;
    int n = 0;
    bus_t bus_q[$];
    clk_t clk_q[$];
    int m_en[CH], m_pol[CH], m_div[CH], m_burst[CH], m_sh[CH], m_n0[CH];
    int pos_cnt[CH];
    logic [CH-1:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic logic [7:0] m_read(input int c, input int rg);
        if (c >= CH) return 8'h00;
        case (rg)
            0:       return 8'(m_en[c] * 128 + m_pol[c] * 2 + m_en[c]);
            1:       return 8'(m_div[c] % 256);
            2:       return 8'(m_div[c] / 256);
            3:       return 8'(m_burst[c]);
            default: return 8'h00;
        endcase
    endfunction

    // Clock output from elapsed time since restart: half period is div+1 edges.
    function automatic logic m_out(input int c);
        if (m_en[c] != 0) return 1'(((n - m_n0[c]) / (m_div[c] + 1) + m_pol[c]) % 2);
        return 1'(m_pol[c]);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_pol[c] = 0; m_div[c] = 0; m_burst[c] = 0; m_sh[c] = 0; m_n0[c] = 0;
        end
        m_prev = '0;
    endtask

    task automatic tick(input logic s, input logic w, input logic [7:0] a, input logic [7:0] d);
        int ch, rg, per;
        bit ok, hit;
        logic [CH-1:0] o;
        bus_t b;
        clk_t e;
        @(negedge clk_i);
        stb_i = s; we_i = w; adr_i = a; dat_i = d;
        ch = int'(a[7:4]);
        rg = int'(a[3:0]);
        ok = (ch < CH);
        n++;
        if (s) begin
            b.n = n;
            b.val = (!w && ok) ? m_read(ch, rg) : 8'h00;
            bus_q.push_back(b);
        end
        for (int c = 0; c < CH; c++) begin
            hit = s && w && ok && (((ch == c) && (rg == 0 || rg == 2 || rg == 3)) || (rg == 5 && d[c]));
            per = 2 * (m_div[c] + 1);
            if (m_en[c] != 0 && m_burst[c] != 0 && n > m_n0[c] &&
                (n - m_n0[c]) % per == 0 && (n - m_n0[c]) / per >= m_burst[c]) begin
                if (hit) m_n0[c] = n;
                else     m_en[c] = 0;
            end
            if (s && w && ok) begin
                if (rg == 5 && d[c]) begin
                    m_en[c] = 1; m_n0[c] = n;
                end else if (ch == c) begin
                    case (rg)
                        0: begin
                            if (d[0] && m_en[c] == 0) m_n0[c] = n;
                            m_en[c] = int'(d[0]); m_pol[c] = int'(d[1]);
                        end
                        1: m_sh[c] = int'(d);
                        2: begin m_div[c] = int'(d) * 256 + m_sh[c]; m_n0[c] = n; end
                        3: m_burst[c] = int'(d);
                        default: ;
                    endcase
                end
            end
            o[c] = m_out(c);
        end
        e.n = n; e.o = o; e.p = o & ~m_prev; e.g = ~o & m_prev;
        m_prev = o;
        clk_q.push_back(e);
    endtask

    task automatic wr(input int c, input int r, input logic [7:0] d);
        tick(1'b1, 1'b1, {4'(c), 4'(r)}, d);
    endtask

    task automatic rd(input int c, input int r);
        tick(1'b1, 1'b0, {4'(c), 4'(r)}, 8'h00);
    endtask

    task automatic idle(input int k);
        repeat (k) tick(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk_i);
            #2;
        end
        rst_i = 1'b1;
        #1;
        check("rst clk_out", 32'(clk_out), 32'h0);
        check("rst clk_pos", 32'(clk_pos), 32'h0);
        check("rst clk_neg", 32'(clk_neg), 32'h0);
        check("rst ack_o", 32'(ack_o), 32'h0);
        check("rst dat_o", 32'(dat_o), 32'h0);
        stb_i = 1'b0; we_i = 1'b0; adr_i = 8'h00; dat_i = 8'h00;
        bus_q.delete();
        clk_q.delete();
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Monitor: compares the DUT against whatever the driver queued for this edge.
    always begin
        clk_t e;
        bus_t b;
        bit exp_ack;
        @(posedge clk_i);
        #1;
        if (clk_q.size() > 0 && clk_q[0].n == n) begin
            e = clk_q.pop_front();
            check("clk_out", 32'(clk_out), 32'(e.o));
            check("clk_pos", 32'(clk_pos), 32'(e.p));
            check("clk_neg", 32'(clk_neg), 32'(e.g));
        end
        exp_ack = (bus_q.size() > 0) && (bus_q[0].n == n);
        check("ack_o", 32'(ack_o), 32'(exp_ack));
        if (exp_ack) begin
            b = bus_q.pop_front();
            check("dat_o", 32'(dat_o), 32'(b.val));
        end else begin
            check("dat_o idle", 32'(dat_o), 32'h0);
        end
        for (int c = 0; c < CH; c++) pos_cnt[c] += int'(clk_pos[c]);
    end

    initial begin
        int p0, r, c, rg, w;
        int regs[6] = '{0, 1, 2, 3, 5, 7};
        logic [7:0] d;
        rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 8'h00; dat_i = 8'h00;
        for (int k = 0; k < CH; k++) pos_cnt[k] = 0;
        model_clear();
        #1;
        do_reset(1'b0);

        for (int k = 0; k < CH; k++) for (int j = 0; j < 4; j++) rd(k, j);

        wr(0, 1, 8'h03); wr(0, 2, 8'h00); wr(0, 0, 8'h01);
        idle(20);

        wr(1, 1, 8'h02); wr(1, 2, 8'h01); rd(1, 1); rd(1, 2);
        wr(1, 0, 8'h01);
        idle(530);
        wr(1, 1, 8'h10);
        idle(530);

        wr(2, 3, 8'h03); wr(2, 1, 8'h01); wr(2, 2, 8'h00);
        p0 = pos_cnt[2];
        wr(2, 0, 8'h01);
        idle(20);
        check("burst clk_pos count", 32'(pos_cnt[2] - p0), 32'd3);
        rd(2, 0);
        wr(2, 0, 8'h02); idle(3);
        wr(2, 0, 8'h03); idle(20); rd(2, 0);

        wr(0, 1, 8'h02); wr(0, 2, 8'h00);
        wr(1, 1, 8'h05); wr(1, 2, 8'h00);
        wr(0, 5, 8'h03);
        idle(80);

        wr(9, 0, 8'h01); wr(0, 7, 8'hff);
        rd(9, 0); rd(0, 7); rd(0, 5); rd(0, 0);
        idle(4);

        repeat (1500) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                idle(1);
            end else begin
                c  = int'($urandom_range(0, 5));
                rg = regs[$urandom_range(0, 5)];
                w  = int'($urandom_range(0, 1));
                d  = 8'($urandom);
                if (rg == 2) d = 8'($urandom_range(0, 1));
                if (rg == 3) begin
                    d = 8'($urandom_range(0, 4));
                    if (c < CH && m_en[c] != 0) w = 0;
                end
                tick(1'b1, 1'(w), {4'(c), 4'(rg)}, d);
            end
        end
        idle(4);

        wr(3, 0, 8'h00); wr(3, 3, 8'h05); wr(3, 1, 8'h03); wr(3, 2, 8'h00);
        wr(3, 0, 8'h01);
        idle(5);
        do_reset(1'b1);
        for (int k = 0; k < CH; k++) rd(k, 0);
        idle(6);

        check("bus queue drained", 32'(bus_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
